// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time and forwards up to MAX_BURST words per grant to a FIFO.
// Optional per-requester accepted-beat counters are enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_full,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         grant_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Handshake: a beat transfers in any cycle where the owner holds req and fifo_full is low;
  // ack/fifo_wr_en mark that cycle and the requester presents its next word afterwards.
  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t               state, state_n;
  logic [IDX_W-1:0]     owner, owner_n;
  logic [IDX_W-1:0]     last_owner, last_owner_n;
  logic [3:0]           burst_cnt, burst_cnt_n;
  logic [NUM_REQ-1:0]   gnt_q, gnt_n;
  logic                 owner_req;
  logic                 accept;
  logic                 at_max;
  logic                 release_now;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First set request searching upward from last+1, wrapping; last itself is checked last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   last);
    logic             found;
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    int               idx;
    found = 1'b0;
    pick  = last;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDX_W'(idx);
      if (!found && r[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    return pick;
  endfunction

  always_comb begin
    owner_req    = req[owner];
    accept       = !rst && (state == S_GRANT) && owner_req && !fifo_full;
    at_max       = accept && (burst_cnt == 4'(MAX_BURST - 1));
    release_now  = (state == S_GRANT) && (!owner_req || at_max);

    state_n      = state;
    owner_n      = owner;
    last_owner_n = last_owner;
    burst_cnt_n  = burst_cnt;
    gnt_n        = gnt_q;

    case (state)
      S_IDLE: begin
        if (|req) begin
          state_n     = S_GRANT;
          owner_n     = rr_pick(req, last_owner);
          burst_cnt_n = '0;
          gnt_n       = onehot(owner_n);
        end
      end
      S_GRANT: begin
        if (accept) burst_cnt_n = burst_cnt + 4'd1;
        if (release_now) begin
          last_owner_n = owner;
          burst_cnt_n  = '0;
          // Back-to-back hand-off; the releasing owner is only re-picked if nobody else asks.
          if (|req) begin
            owner_n = rr_pick(req, owner);
            gnt_n   = onehot(owner_n);
          end else begin
            state_n = S_IDLE;
            gnt_n   = '0;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      burst_cnt  <= '0;
      gnt_q      <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_owner_n;
      burst_cnt  <= burst_cnt_n;
      gnt_q      <= gnt_n;
    end
  end

  assign gnt          = gnt_q;
  assign busy         = (state == S_GRANT);
  assign ack          = accept ? onehot(owner) : '0;
  assign fifo_wr_en   = accept;
  assign fifo_wr_data = accept ? req_data[owner*DATA_WIDTH +: DATA_WIDTH] : '0;

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_q [NUM_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept && (owner == IDX_W'(i)) && (stat_q[i] != 16'hFFFF))
          stat_q[i] <= stat_q[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign grant_cnt[g*16 +: 16] = stat_q[g];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a behavioural arbitration model.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int MAXB  = 4;
  localparam int DW    = 8;
  localparam int LIMIT = (NREQ - 1) * MAXB;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic              fifo_full = 1'b0;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   gnt;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic              busy;
`ifdef FIFO_ARB_STATS_EN
  logic [NREQ*16-1:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NREQ), .MAX_BURST(MAXB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .gnt          (gnt),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .busy         (busy)
`ifdef FIFO_ARB_STATS_EN
    ,
    .grant_cnt    (grant_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int              m_busy  = 0;
  int              m_owner = 0;
  int              m_cnt   = 0;
  int              m_last  = NREQ - 1;
  logic [NREQ-1:0] m_ack_prev = '0;
  int              wait_beats [NREQ];
  int              m_stat [NREQ];

  // Winner = requester at smallest clockwise distance after 'last'.
  function automatic int pick(input logic [NREQ-1:0] r, input int last);
    int best;
    int bd;
    int d;
    best = -1;
    bd   = NREQ + 1;
    for (int i = 0; i < NREQ; i++) begin
      if (r[i]) begin
        d = (i - last - 1 + 2 * NREQ) % NREQ;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      wait_beats[i] = 0;
      m_stat[i]     = 0;
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  always @(negedge clk) begin
    logic [NREQ-1:0] e_gnt;
    logic [NREQ-1:0] e_ack;
    logic [DW-1:0]   e_data;
    logic            acc;
    e_gnt  = m_busy ? NREQ'(1 << m_owner) : '0;
    acc    = !rst && (m_busy != 0) && req[m_owner] && !fifo_full;
    e_ack  = acc ? NREQ'(1 << m_owner) : '0;
    e_data = acc ? req_data[m_owner*DW +: DW] : '0;

    chk("gnt",        32'(gnt),           32'(e_gnt));
    chk("busy",       32'(busy),          32'(m_busy != 0));
    chk("ack",        32'(ack),           32'(e_ack));
    chk("fifo_wr_en", 32'(fifo_wr_en),    32'(acc));
    chk("wr_data",    32'(fifo_wr_data),  32'(e_data));
    chk("burst_cnt",  32'(dut.burst_cnt), 32'(m_cnt));

    for (int i = 0; i < NREQ; i++) begin
      if (rst || ack[i] || !req[i]) begin
        wait_beats[i] = 0;
      end else if (|ack) begin
        wait_beats[i]++;
        n_checks++;
        if (wait_beats[i] > LIMIT) begin
          n_fail++;
          $display("FAIL fairness req%0d: waited %0d beats, limit %0d", i, wait_beats[i], LIMIT);
        end
      end
    end

    for (int i = 0; i < NREQ; i++) begin
      if (rst) m_stat[i] = 0;
      else if (e_ack[i] && m_stat[i] < 65535) m_stat[i]++;
    end

    m_ack_prev = e_ack;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_cnt = 0; m_last = NREQ - 1;
    end else if (m_busy == 0) begin
      if (req != '0) begin
        m_owner = pick(req, m_last);
        m_busy  = 1;
        m_cnt   = 0;
      end
    end else begin
      if (acc) m_cnt++;
      if (!req[m_owner] || m_cnt == MAXB) begin
        m_last = m_owner;
        m_cnt  = 0;
        if (req != '0) m_owner = pick(req, m_last);
        else begin
          m_busy  = 0;
          m_owner = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst       = 1'b1;
    req       = '0;
    fifo_full = 1'b0;
    tick();
    tick();
    rst       = 1'b0;
  endtask

  task automatic set_lane(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int beats;
    int o;

    // Reset values
    do_reset();
    look();
    chk("rst_gnt",  32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ack",  32'(ack), 32'h0);

    // Single requester 1: four beats, re-grant on the same edge, no bubble
    do_reset();
    req = 4'b0010;
    set_lane(1, 8'hA1);
    look();
    chk("single_idle_gnt", 32'(gnt), 32'h0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      set_lane(1, 8'(8'hA0 + k));
      look();
      chk("single_ack",  32'(ack), 32'h2);
      chk("single_data", 32'(fifo_wr_data), 32'(8'hA0 + k));
      chk("single_cnt",  32'(dut.burst_cnt), 32'((k - 1) % 4));
    end

    // All requesters: order 0,1,2,3,0 with four beats each
    do_reset();
    req      = 4'hF;
    req_data = 32'h44332211;
    look();
    chk("all_idle_ack", 32'(ack), 32'h0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      look();
      o = ((k - 1) / 4) % 4;
      chk("all_ack",  32'(ack), 32'(1 << o));
      chk("all_gnt",  32'(gnt), 32'(1 << o));
      chk("all_data", 32'(fifo_wr_data), 32'(8'h11 * (o + 1)));
    end

    // Backpressure on owner 2 mid-burst
    do_reset();
    req   = 4'b0100;
    beats = 0;
    set_lane(2, 8'h30);
    for (int k = 1; k <= 7; k++) begin
      tick();
      fifo_full = (k >= 3 && k <= 5);
      set_lane(2, 8'(8'h30 + beats));
      look();
      chk("bp_gnt", 32'(gnt), 32'h4);
      if (k >= 3 && k <= 5) begin
        chk("bp_ack",   32'(ack), 32'h0);
        chk("bp_wr_en", 32'(fifo_wr_en), 32'h0);
        chk("bp_cnt",   32'(dut.burst_cnt), 32'h2);
      end
      if (ack[2]) beats++;
    end
    chk("bp_beats", 32'(beats), 32'd4);
    tick();
    req = '0;
    look();
    chk("bp_regrant_gnt", 32'(gnt), 32'h4);
    tick();
    look();
    chk("bp_idle_gnt", 32'(gnt), 32'h0);

    // Early drop by owner 0 hands over to requester 3
    do_reset();
    req = 4'b1001;
    req_data = 32'h5500_0066;
    for (int k = 1; k <= 2; k++) begin
      tick();
      look();
      chk("drop_ack0", 32'(ack), 32'h1);
    end
    tick();
    req = 4'b1000;
    look();
    chk("drop_gap_ack", 32'(ack), 32'h0);
    chk("drop_gap_gnt", 32'(gnt), 32'h1);
    tick();
    look();
    chk("drop_gnt3", 32'(gnt), 32'h8);
    chk("drop_cnt",  32'(dut.burst_cnt), 32'h0);
    chk("drop_ack3", 32'(ack), 32'h8);

    // Reset during owner 1's third beat
    do_reset();
    req = 4'b0010;
    for (int k = 1; k <= 2; k++) begin
      tick();
      look();
      chk("rstmid_ack", 32'(ack), 32'h2);
    end
    tick();
    rst = 1'b1;
    look();
    chk("rstmid_noack", 32'(ack), 32'h0);
    chk("rstmid_nowr",  32'(fifo_wr_en), 32'h0);
    chk("rstmid_data",  32'(fifo_wr_data), 32'h0);
    tick();
    rst = 1'b0;
    req = 4'b0011;
    look();
    chk("rstmid_gnt0", 32'(gnt), 32'h0);
    tick();
    look();
    chk("rstmid_first", 32'(gnt), 32'h1);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst       = ($urandom_range(0, 299) == 0);
      fifo_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (m_ack_prev[i]) begin
          req[i] = ($urandom_range(0, 9) < 7);
          set_lane(i, 8'($urandom));
        end else if (req[i]) begin
          if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          set_lane(i, 8'($urandom));
        end
      end
    end
    tick();
    rst = 1'b0;
    req = '0;
    look();

`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++)
      chk("grant_cnt", 32'(grant_cnt[i*16 +: 16]), 32'(m_stat[i]));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
